// File: rtl/loop_branch_unit.sv
// Loop-control engine beside the fetch unit: keeps a stack of loop-body start
// addresses, redirects the PC on a taken close and squashes skipped loop bodies.
module loop_branch_unit #(
    parameter int                    DEPTH     = 16,
    parameter int                    OP_WIDTH  = 8,
    parameter logic [OP_WIDTH-1:0]   OPC_OPEN  = 8'h5B,
    parameter logic [OP_WIDTH-1:0]   OPC_CLOSE = 8'h5D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               pc,
    input  logic [OP_WIDTH-1:0]       instruction,
    input  logic                      cell_zero,
    output logic                      pc_src,
    output logic [15:0]               pc_loaded,
    output logic                      squash,
    output logic                      fault,
    output logic [$clog2(DEPTH):0]    depth
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              SW   = AW + 1;
    localparam logic [SW-1:0]   FULL = SW'(DEPTH);
    localparam logic [SW-1:0]   ONE  = SW'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_SKIP  = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   sp_q, sp_d;
    logic [SW-1:0]   skip_cnt_q, skip_cnt_d;
    logic [15:0]     stack_q [DEPTH];

    logic            is_open, is_close;
    logic            push;
    logic            goto_fault;
    logic [SW-1:0]   sp_m1;
    logic [15:0]     top;

    assign is_open  = (instruction == OPC_OPEN);
    assign is_close = (instruction == OPC_CLOSE);
    assign sp_m1    = sp_q - ONE;
    assign top      = stack_q[sp_m1[AW-1:0]];
    assign depth    = sp_q;

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        skip_cnt_d = skip_cnt_q;
        push       = 1'b0;
        goto_fault = 1'b0;
        pc_src     = 1'b0;
        squash     = 1'b0;
        fault      = 1'b0;
        pc_loaded  = (sp_q != '0) ? top : 16'h0000;

        unique case (state_q)
            S_RUN: begin
                if (is_open) begin
                    if (cell_zero) begin
                        skip_cnt_d = ONE;
                        state_d    = S_SKIP;
                        squash     = 1'b1;
                    end else if (sp_q == FULL) begin
                        goto_fault = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + ONE;
                    end
                end else if (is_close) begin
                    if (sp_q == '0) begin
                        goto_fault = 1'b1;
                    end else if (!cell_zero) begin
                        // Loop back: top already holds the body start; the pop
                        // happens only on the final, falling-through close.
                        pc_src = 1'b1;
                    end else begin
                        sp_d = sp_m1;
                    end
                end
            end
            S_SKIP: begin
                squash = 1'b1;
                if (is_open) begin
                    if (skip_cnt_q == FULL) goto_fault = 1'b1;
                    else                    skip_cnt_d = skip_cnt_q + ONE;
                end else if (is_close) begin
                    skip_cnt_d = skip_cnt_q - ONE;
                    if (skip_cnt_q == ONE) state_d = S_RUN;
                end
            end
            default: goto_fault = 1'b1;
        endcase

        // The faulting instruction itself is already held and squashed.
        if (goto_fault) begin
            state_d    = S_FAULT;
            sp_d       = sp_q;
            skip_cnt_d = skip_cnt_q;
            push       = 1'b0;
            pc_src     = 1'b1;
            pc_loaded  = pc;
            squash     = 1'b1;
            fault      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            sp_q       <= '0;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    // Stack contents need no reset: entries are only read below sp.
    always_ff @(posedge clk) begin
        if (push) stack_q[sp_q[AW-1:0]] <= pc + 16'd1;
    end

endmodule

// File: doc/loop_branch_unit.md
# loop_branch_unit

Loop-control engine that drives the `pc_src` / `pc_loaded` inputs of the fetch unit. It decodes the loop-open and loop-close opcodes currently presented by instruction memory and keeps a hardware stack of loop-body start addresses. When the current data cell is zero it performs a forward bracket-matching skip; otherwise it redirects the PC back to the loop body. It sits beside the fetch unit and gates execution of the datapath through `squash`.

## Interface
- `DEPTH`, 16, loop-stack entries and maximum skip nesting; power of two, ≥2.
- `OP_WIDTH`, 8, instruction width.
- `OPC_OPEN`, 8'h5B, loop-open opcode.
- `OPC_CLOSE`, 8'h5D, loop-close opcode.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  in  16  current PC, the register output of the fetch unit.
- `instruction`  in  OP_WIDTH  opcode at `pc`, combinational from instruction ROM.
- `cell_zero`  in  1  current data cell == 0; valid in the same cycle as `instruction`.
- `pc_src`  out  1  1 = fetch loads `pc_loaded`; 0 = fetch increments.
- `pc_loaded`  out  16  jump target.
- `squash`  out  1  1 = datapath must not execute `instruction` this cycle.
- `fault`  out  1  sticky error flag.
- `depth`  out  $clog2(DEPTH)+1  current stack occupancy.

## Operation
- States: RUN, SKIP, FAULT. Registers: `stack[DEPTH]` of 16 bits, `sp`, `skip_cnt` ($clog2(DEPTH)+1 bits).
- Outputs are Mealy: combinational from state, `instruction`, `cell_zero`, `sp`, and stack top. Registered state updates only on posedge.
- `pc_loaded` = `stack[sp-1]` when `sp` > 0, else 16'h0000. FAULT overrides this, see below.

RUN
- `OPC_OPEN`, `cell_zero`=0, `sp`<DEPTH:
  - push `pc+1` (mod 2^16);
  - `pc_src`=0, `squash`=0.
- `OPC_OPEN`, `cell_zero`=1:
  - no push;
  - `skip_cnt`←1, go to SKIP;
  - `squash`=1, `pc_src`=0.
- `OPC_CLOSE`, `sp`>0, `cell_zero`=0: `pc_src`=1, `pc_loaded`=top. No pop.
- `OPC_CLOSE`, `sp`>0, `cell_zero`=1: pop, `pc_src`=0.
- `OPC_OPEN` with `cell_zero`=0 and `sp`==DEPTH: go to FAULT.
- `OPC_CLOSE` with `sp`==0: go to FAULT.
- Any other opcode: `pc_src`=0, `squash`=0, no state change.

SKIP
- `squash`=1 and `pc_src`=0 every cycle. Stack is untouched and `cell_zero` is ignored.
- `OPC_OPEN`: `skip_cnt`+1. If the result would exceed DEPTH, go to FAULT.
- `OPC_CLOSE`: `skip_cnt`−1. At zero, return to RUN. The matching close is itself squashed.
- `pc` wrapping 16'hFFFF→0 during SKIP is legal and not an error.

FAULT
- `pc_src`=1, `pc_loaded`=`pc` (PC holds), `squash`=1, `fault`=1.
- Exit only through `rst_n`.

## Timing
- Reset, while `rst_n`=0 and immediately after release:
  - state=RUN, `sp`=0, `skip_cnt`=0, `fault`=0, `depth`=0;
  - `pc_src`=0, `pc_loaded`=0, `squash`=0 (assuming a non-loop opcode is presented).
  - Stack contents are don't-care.
- Reset asserted mid-SKIP or mid-FAULT returns to RUN asynchronously. No posedge is required.
- Decision latency is 0 cycles: `pc_src` / `pc_loaded` are valid in the same cycle as `instruction`, so the fetch unit's next-edge PC update sees them.
- Push and pop take effect at the posedge ending the decoding cycle. `depth` reflects the new value from the next cycle.
- A taken close costs no bubble: the next cycle fetches the body start.
- A skip costs one squashed cycle per skipped instruction, including both the open and the matching close.
- `cell_zero` must reflect the result of the previous instruction. The datapath guarantees forwarding.

## Test plan
- Basic loop: `[` at 0x0010 with `cell_zero`=0.
  - Next cycle `depth`=1.
  - `]` at 0x0014 with `cell_zero`=0 → `pc_src`=1, `pc_loaded`=0x0011.
  - Later `]` with `cell_zero`=1 → `pc_src`=0, `depth`=0.
- Skip nested: `[` at 0x0020 with `cell_zero`=1, followed by the sequence `[`, `]`, `]`.
  - `squash`=1 on all four cycles.
  - RUN resumes at 0x0024 with `squash`=0.
  - `depth` stays 0 throughout.
- Overflow: DEPTH+1 consecutive `[` with `cell_zero`=0.
  - `fault`=1 on the 17th open.
  - `pc_src`=1, `pc_loaded`=`pc`.
  - Subsequent opcodes are ignored until reset.
- Underflow: `]` with `sp`=0 → `fault`=1, `squash`=1.
- Wrap: `[` at 0xFFFF with `cell_zero`=0 pushes 0x0000. A following `]` with `cell_zero`=0 gives `pc_loaded`=0x0000.
- Reset mid-SKIP: assert `rst_n`=0 while `skip_cnt`=2 → state RUN, `squash`=0, `depth`=0, `fault`=0 with no clock edge.
